// File: rtl/main_run_sequencer.sv
// main_run_sequencer
//   Runs one invocation of the HLS kernel `main` through its slave RAM port:
//   load a host byte stream into kernel memory, pulse start_port and count
//   cycles until done_port (or a timeout), then stream the result bytes back.
//   This block is the only driver of main's slave port. Only channel 0 is
//   used; every other channel is held at zero.
//
// Ports
//   clock, reset            single clock (posedge); reset is async, active low
//   cmd_go/cmd_base/cmd_len start a sequence (ignored while busy)
//   in_valid/in_ready/in_data      load byte stream
//   out_valid/out_ready/out_data   readback byte stream
//   busy, run_done, run_timeout, run_cycles   status
//   start_port / done_port  kernel handshake
//   S_*_ram, Sout_*         kernel slave RAM port (CHANNELS wide)
module main_run_sequencer #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 7,
  parameter int TIMEOUT  = 200000000,
  parameter int CNT_W    = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_go,
  input  logic [ADDR_W-1:0]            cmd_base,
  input  logic [ADDR_W:0]              cmd_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         busy,
  output logic                         run_done,
  output logic                         run_timeout,
  output logic [CNT_W-1:0]             run_cycles,
  output logic                         start_port,
  input  logic                         done_port,
  output logic [CHANNELS-1:0]          S_oe_ram,
  output logic [CHANNELS-1:0]          S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]          Sout_DataRdy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_READ_OUT  = 3'd6;
  localparam logic [2:0] S_FIN       = 3'd7;

  // Longest transfer is one full address space.
  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [CNT_W-1:0]  TO_LIM    = CNT_W'(TIMEOUT);
  localparam logic [SIZE_W-1:0] BYTE_SIZE = SIZE_W'(8);

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   idx;
  logic [CNT_W-1:0]  cnt;
  logic              we0, oe0;
  logic [ADDR_W-1:0] addr0;
  logic [7:0]        wdata0;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   idx_nxt;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] addr_nxt;

  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign idx_nxt     = idx + 1'b1;
  // Addresses wrap naturally in ADDR_W bits.
  assign addr_cur    = base + idx[ADDR_W-1:0];
  assign addr_nxt    = base + idx_nxt[ADDR_W-1:0];

  // Handshake/status outputs are pure state decodes, so an async reset
  // clears them immediately and FIN yields exactly one run_done cycle.
  assign in_ready   = (state == S_LOAD);
  assign start_port = (state == S_START);
  assign run_done   = (state == S_FIN);
  assign busy       = (state != S_IDLE);

  // Channel 0 in the low slice, all other channels zero-extended away.
  assign S_we_ram        = CHANNELS'(we0);
  assign S_oe_ram        = CHANNELS'(oe0);
  assign S_addr_ram      = (CHANNELS*ADDR_W)'(addr0);
  assign S_Wdata_ram     = (CHANNELS*DATA_W)'(wdata0);
  assign S_data_ram_size = (CHANNELS*SIZE_W)'((we0 | oe0) ? BYTE_SIZE : '0);

  // Upper read-data bits and other channels' ready lines are don't-care.
  logic unused_in;
  assign unused_in = ^{Sout_Rdata_ram, Sout_DataRdy};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      base        <= '0;
      len         <= '0;
      idx         <= '0;
      cnt         <= '0;
      we0         <= 1'b0;
      oe0         <= 1'b0;
      addr0       <= '0;
      wdata0      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      run_timeout <= 1'b0;
      run_cycles  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_go) begin
            base        <= cmd_base;
            len         <= len_clamped;
            idx         <= '0;
            cnt         <= CNT_W'(1);
            run_timeout <= 1'b0;
            state       <= (len_clamped == '0) ? S_START : S_LOAD;
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            we0    <= 1'b1;
            addr0  <= addr_cur;
            wdata0 <= in_data;
            state  <= S_LOAD_WAIT;
          end
        end

        // we/addr/data stay put until the kernel acknowledges the write.
        S_LOAD_WAIT: begin
          if (Sout_DataRdy[0]) begin
            we0 <= 1'b0;
            if (idx_nxt == len) begin
              idx   <= '0;
              cnt   <= CNT_W'(1);
              state <= S_START;
            end else begin
              idx   <= idx_nxt;
              state <= S_LOAD;
            end
          end
        end

        // The START cycle is run cycle 1; done_port is already honoured here.
        // cnt never passes TO_LIM, which gives the saturation.
        S_START, S_RUN: begin
          if (done_port) begin
            run_cycles <= cnt;
            if (len == '0) begin
              state <= S_FIN;
            end else begin
              idx   <= '0;
              oe0   <= 1'b1;
              addr0 <= base;
              state <= S_READ;
            end
          end else if (cnt >= TO_LIM) begin
            run_timeout <= 1'b1;
            run_cycles  <= TO_LIM;
            state       <= S_FIN;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_RUN;
          end
        end

        S_READ: begin
          if (Sout_DataRdy[0]) begin
            oe0       <= 1'b0;
            out_data  <= Sout_Rdata_ram[7:0];
            out_valid <= 1'b1;
            state     <= S_READ_OUT;
          end
        end

        S_READ_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_nxt == len) begin
              state <= S_FIN;
            end else begin
              idx   <= idx_nxt;
              oe0   <= 1'b1;
              addr0 <= addr_nxt;
              state <= S_READ;
            end
          end
        end

        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_run_sequencer.sv
// tb_main_run_sequencer
//   Directed bench for main_run_sequencer with a behavioural `main`:
//   64-byte RAM, DataRdy 2 cycles after a read request, 1 after a write,
//   done_port a configurable number of cycles after start (START = cycle 1),
//   optional sort of the RAM when done. A second instance with TIMEOUT=100
//   and a kernel that never finishes covers the timeout path.
module tb_main_run_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- main DUT ----------------
  logic        cmd_go = 0;
  logic [7:0]  cmd_base = 0;
  logic [8:0]  cmd_len = 0;
  logic        in_valid = 0, in_ready;
  logic [7:0]  in_data = 0;
  logic        out_valid, out_ready = 0;
  logic [7:0]  out_data;
  logic        busy, run_done, run_timeout, start_port, done_port;
  logic [31:0] run_cycles;
  logic [1:0]  S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [15:0] S_addr_ram;
  logic [127:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [13:0] S_data_ram_size;

  main_run_sequencer dut (
    .clock(clock), .reset(reset), .cmd_go(cmd_go), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .run_done(run_done), .run_timeout(run_timeout), .run_cycles(run_cycles),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  // ---------------- behavioural kernel ----------------
  typedef logic [7:0] mem_t [64];
  mem_t mem;
  mem_t srt;
  logic [7:0] wlog [256];
  int   wcnt = 0, rcnt = 0;
  logic rdy = 0, pend = 0;
  logic [7:0] raddr = 0, rdata = 0;
  logic running = 0;
  int   mcnt = 0;
  int   run_dly = 0;      // 0 = never finishes
  bit   sort_en = 0;

  always_comb begin
    logic [7:0] t;
    srt = mem;
    for (int i = 0; i < 63; i++)
      for (int j = 0; j < 63 - i; j++)
        if (srt[j] > srt[j+1]) begin
          t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t;
        end
  end

  assign done_port = (run_dly != 0) &&
                     ((start_port && run_dly == 1) || (running && (mcnt + 1) >= run_dly));
  assign Sout_DataRdy   = {1'b1, rdy};
  assign Sout_Rdata_ram = {64'hDEADBEEF_CAFEF00D, 56'h0, rdata};

  always @(posedge clock) begin
    if (rdy) rdy <= 1'b0;
    else if (pend) begin
      pend  <= 1'b0;
      rdy   <= 1'b1;
      rdata <= mem[raddr[5:0]];
    end else if (S_we_ram[0]) begin
      mem[S_addr_ram[5:0]] <= S_Wdata_ram[7:0];
      rdy <= 1'b1;
      wlog[wcnt % 256] <= S_addr_ram[7:0];
      wcnt <= wcnt + 1;
    end else if (S_oe_ram[0]) begin
      pend  <= 1'b1;
      raddr <= S_addr_ram[7:0];
      rcnt  <= rcnt + 1;
    end
    if (done_port) begin
      running <= 1'b0;
      if (sort_en) mem <= srt;
    end else if (start_port) begin
      running <= 1'b1;
      mcnt    <= 1;
    end else if (running) mcnt <= mcnt + 1;
  end

  // ---------------- protocol monitors ----------------
  int ovl = 0, ch1 = 0, szv = 0, stv = 0;
  logic p_we = 0, p_ov = 0, p_or = 0;
  logic [7:0] p_addr = 0, p_wd = 0, p_od = 0;
  always @(posedge clock) begin
    if (S_we_ram[0] && S_oe_ram[0]) ovl <= ovl + 1;
    if (S_we_ram[1] || S_oe_ram[1] || (|S_addr_ram[15:8]) || (|S_Wdata_ram[127:64]) ||
        (|S_data_ram_size[13:7])) ch1 <= ch1 + 1;
    if ((S_we_ram[0] || S_oe_ram[0]) && S_data_ram_size[6:0] != 7'd8) szv <= szv + 1;
    if ((p_we && S_we_ram[0] && (S_addr_ram[7:0] != p_addr || S_Wdata_ram[7:0] != p_wd)) ||
        (p_ov && !p_or && (!out_valid || out_data != p_od))) stv <= stv + 1;
    p_we <= S_we_ram[0]; p_addr <= S_addr_ram[7:0]; p_wd <= S_Wdata_ram[7:0];
    p_ov <= out_valid; p_or <= out_ready; p_od <= out_data;
  end

  // ---------------- timeout DUT (TIMEOUT=100, kernel never done) ----------------
  logic        t_cmd_go = 0, t_in_ready, t_out_valid, t_busy, t_run_done, t_run_timeout, t_start;
  logic [7:0]  t_out_data;
  logic [31:0] t_run_cycles;
  logic [1:0]  t_oe, t_we;
  logic [15:0] t_addr;
  logic [127:0] t_wdata;
  logic [13:0] t_size;
  logic        t_rdy = 0;
  int          t_rcnt = 0;

  main_run_sequencer #(.TIMEOUT(100)) dut_to (
    .clock(clock), .reset(reset), .cmd_go(t_cmd_go), .cmd_base(8'h00), .cmd_len(9'd2),
    .in_valid(1'b1), .in_ready(t_in_ready), .in_data(8'hA5),
    .out_valid(t_out_valid), .out_ready(1'b1), .out_data(t_out_data),
    .busy(t_busy), .run_done(t_run_done), .run_timeout(t_run_timeout), .run_cycles(t_run_cycles),
    .start_port(t_start), .done_port(1'b0),
    .S_oe_ram(t_oe), .S_we_ram(t_we), .S_addr_ram(t_addr),
    .S_Wdata_ram(t_wdata), .S_data_ram_size(t_size),
    .Sout_Rdata_ram(128'h0), .Sout_DataRdy({1'b0, t_rdy})
  );

  always @(posedge clock) begin
    t_rdy <= (t_we[0] | t_oe[0]) & ~t_rdy;
    if (t_oe[0]) t_rcnt <= t_rcnt + 1;
  end

  // ---------------- stimulus ----------------
  logic [7:0] src [64];
  logic [7:0] got [64];
  int g_nout, g_ndone;

  // One full sequence; returns readback in got[], counts in g_nout/g_ndone.
  task automatic do_run(input logic [7:0] b, input int len, input int dly,
                        input bit stall, input bit poke);
    int nin, nout, ndone, cyc;
    bit poked;
    run_dly = dly;
    @(negedge clock);
    cmd_base = b; cmd_len = 9'(len); cmd_go = 1'b1;
    @(negedge clock);
    nin = 0; nout = 0; ndone = 0; cyc = 0; poked = 0;
    while (ndone == 0 && cyc < 5000) begin
      if (poke && !poked && nin == 1) begin
        cmd_go = 1'b1; cmd_base = 8'h20; cmd_len = 9'd1; poked = 1;
      end else cmd_go = 1'b0;
      in_valid  = (nin < len) && (!stall || $urandom_range(0, 2) != 0);
      in_data   = src[nin % 64];
      out_ready = !stall || $urandom_range(0, 1) == 1;
      if (in_valid && in_ready) nin++;
      if (out_valid && out_ready) begin
        if (nout < 64) got[nout] = out_data;
        nout++;
      end
      if (run_done) ndone++;
      @(negedge clock);
      cyc++;
    end
    chk("run_bound", 64'(cyc < 5000), 64'd1);
    cmd_go = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (run_done) ndone++;
      @(negedge clock);
    end
    g_nout = nout; g_ndone = ndone;
  endtask

  initial begin
    int w0, r0, bad, nin, cyc, dn;
    logic [7:0] ea;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ctl", {busy, in_ready, out_valid, run_done, run_timeout, start_port, S_we_ram, S_oe_ram}, 0);
    chk("rst_cycles", run_cycles, 0);
    reset = 1'b1;

    // Test 2: 64 descending bytes, kernel sorts, done after 500 cycles
    for (int i = 0; i < 64; i++) src[i] = 8'(8'h3F - i);
    sort_en = 1; w0 = wcnt;
    do_run(8'h00, 64, 500, 0, 0);
    sort_en = 0;
    chk("t2_cycles", run_cycles, 500);
    chk("t2_timeout", run_timeout, 0);
    chk("t2_ndone", g_ndone, 1);
    chk("t2_nout", g_nout, 64);
    chk("t2_writes", wcnt - w0, 64);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== 8'(i)) bad++;
    chk("t2_data_bad", bad, 0);

    // Test 1: reset after 10 load bytes, then a clean restart
    @(negedge clock);
    cmd_base = 8'h00; cmd_len = 9'd20; cmd_go = 1'b1;
    @(negedge clock);
    cmd_go = 1'b0; nin = 0; cyc = 0;
    while (nin < 10 && cyc < 200) begin
      in_valid = 1'b1; in_data = 8'(nin);
      if (in_ready) nin++;
      @(negedge clock); cyc++;
    end
    in_valid = 1'b0;
    chk("t1_bound", 64'(cyc < 200), 64'd1);
    chk("t1_busy_before", busy, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("t1_ctl", {busy, in_ready, out_valid, run_done, run_timeout, start_port, S_we_ram, S_oe_ram}, 0);
    chk("t1_cycles", run_cycles, 0);
    dn = 0;
    repeat (3) begin @(negedge clock); if (run_done) dn++; end
    chk("t1_no_done", dn, 0);
    reset = 1'b1;
    src[0] = 8'h5A; src[1] = 8'hC3;
    do_run(8'h05, 2, 5, 0, 0);
    chk("t1r_cycles", run_cycles, 5);
    chk("t1r_ndone", g_ndone, 1);
    chk("t1r_d0", got[0], 8'h5A);
    chk("t1r_d1", got[1], 8'hC3);

    // Test 3: zero length, done 3 cycles after start
    w0 = wcnt; r0 = rcnt;
    do_run(8'h10, 0, 3, 0, 0);
    chk("t3_cycles", run_cycles, 3);
    chk("t3_ndone", g_ndone, 1);
    chk("t3_access", (wcnt - w0) + (rcnt - r0), 0);
    chk("t3_nout", g_nout, 0);

    // Test 5: wrapping base with random stalls
    for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
    w0 = wcnt;
    do_run(8'hFE, 4, 20, 1, 0);
    chk("t5_writes", wcnt - w0, 4);
    for (int k = 0; k < 4; k++) begin
      ea = 8'hFE + 8'(k);
      chk("t5_waddr", wlog[(w0 + k) % 256], ea);
      chk("t5_data", got[k], src[k]);
    end
    chk("t5_cycles", run_cycles, 20);
    chk("t5_stable", stv, 0);
    chk("t5_overlap", ovl, 0);

    // Test 6: done in START cycle, cmd_go while busy ignored
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    w0 = wcnt;
    do_run(8'h10, 3, 1, 0, 1);
    chk("t6_cycles", run_cycles, 1);
    chk("t6_ndone", g_ndone, 1);
    chk("t6_nout", g_nout, 3);
    chk("t6_writes", wcnt - w0, 3);
    chk("t6_waddr2", wlog[(w0 + 2) % 256], 8'h12);
    chk("t6_d2", got[2], 8'h33);

    // Test 4: timeout instance
    @(negedge clock);
    t_cmd_go = 1'b1;
    @(negedge clock);
    t_cmd_go = 1'b0;
    chk("t4_busy", t_busy, 1);
    dn = 0; cyc = 0;
    while (dn == 0 && cyc < 400) begin
      if (t_run_done) dn++;
      @(negedge clock); cyc++;
    end
    repeat (3) begin if (t_run_done) dn++; @(negedge clock); end
    chk("t4_bound", 64'(cyc < 400), 64'd1);
    chk("t4_ndone", dn, 1);
    chk("t4_timeout", t_run_timeout, 1);
    chk("t4_cycles", t_run_cycles, 100);
    chk("t4_no_oe", t_rcnt, 0);
    chk("t4_idle", t_busy, 0);

    // Global slave-port rules
    chk("overlap", ovl, 0);
    chk("ch1_zero", ch1, 0);
    chk("size8", szv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
